// File: rtl/divider_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned, with sign fixup on completion.
// Optional build macro DIVIDER_ITER_EARLY_EXIT_EN finishes in one cycle when |dividend| < |divisor|.
module divider_iter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             data_ok,
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for valid; accepts and latches operands
    // BUSY  | one shift-subtract step per cycle, counter counts down to terminal count
    // DONE  | results registered, data_ok pulses, back to IDLE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             early;

    assign a_neg = is_signed & srca[WIDTH-1];
    assign b_neg = is_signed & srcb[WIDTH-1];
    // the most-negative value negates to itself and is read as unsigned 2^(WIDTH-1)
    assign a_mag = a_neg ? (~srca + ONE_W) : srca;
    assign b_mag = b_neg ? (~srcb + ONE_W) : srcb;

`ifdef DIVIDER_ITER_EARLY_EXIT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // partial remainder gets one extra bit: an unsigned divisor may exceed 2^(WIDTH-1)
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] prem_nx;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign rem_sh  = {prem, dvd[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign ge      = ~diff[WIDTH];
    assign prem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign q_mag   = {dvd[WIDTH-2:0], ge};
    assign q_fix   = neg_q ? (~q_mag + ONE_W) : q_mag;
    assign r_fix   = neg_r ? (~prem_nx + ONE_W) : prem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            dvd   <= '0;
            prem  <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            quot  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        dvd   <= a_mag;
                        prem  <= '0;
                        dvs   <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (srcb == '0) begin
                            quot  <= '1;
                            rem   <= srca;
                            cnt   <= '0;
                            state <= S_DONE;
                        end else if (early) begin
                            quot  <= '0;
                            rem   <= srca;
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!valid) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        dvd  <= q_mag;
                        prem <= prem_nx;
                        cnt  <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            quot  <= q_fix;
                            rem   <= r_fix;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_ok = (state == S_DONE);
    assign busy    = (state == S_BUSY);

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter: expected results are queued when an operation is driven
// and popped when data_ok appears; latency and busy-cycle counts are checked alongside.
module tb_divider_iter;
    localparam int W = 64;

    logic         clk;
    logic         resetn;
    logic         valid;
    logic         is_signed;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         data_ok;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    divider_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .quot      (quot),
        .rem       (rem),
        .data_ok   (data_ok),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic an, bn;
        logic [W-1:0] am, bm, q, r;
        if (b == '0) return {{W{1'b1}}, a};
        an = s & a[W-1];
        bn = s & b[W-1];
        am = an ? -a : a;
        bm = bn ? -b : b;
        q  = am / bm;
        r  = am % bm;
        if (an ^ bn) q = -q;
        if (an) r = -r;
        return {q, r};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
`ifdef DIVIDER_ITER_EARLY_EXIT_EN
        logic [W-1:0] am, bm;
        am = (s & a[W-1]) ? -a : a;
        bm = (s & b[W-1]) ? -b : b;
        if (b != '0 && am < bm) return 1;
`endif
        if (b == '0) return 1;
        return W + 1;
    endfunction

    // Waits for data_ok with a cycle budget; returns edges seen and cycles with busy high.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nb++;
        end while (!data_ok && n < 300);
        if (!data_ok) chk("timeout", 64'(data_ok), 64'(1));
    endtask

    task automatic pop_cmp(input string tag);
        logic [2*W-1:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
            return;
        end
        e = sb.pop_front();
        chk({tag, "_quot"}, quot, e[2*W-1:W]);
        chk({tag, "_rem"}, rem, e[W-1:0]);
        last_q = e[2*W-1:W];
        last_r = e[W-1:0];
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        int n, nb, lat;
        lat = exp_lat(a, b, s);
        sb.push_back({eq, er});
        srca      = a;
        srcb      = b;
        is_signed = s;
        valid     = 1'b1;
        wait_done(n, nb);
        valid = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busycyc"}, 64'(nb), 64'(lat - 1));
        pop_cmp(tag);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(data_ok), 64'(0));
    endtask

    initial begin
        logic [2*W-1:0] e;
        logic [W-1:0] ra, rb;
        logic rs;
        int n, nb, hi;

        resetn    = 1'b0;
        valid     = 1'b0;
        is_signed = 1'b0;
        srca      = '0;
        srcb      = '0;
        #1;
        chk("rst_quot", quot, '0);
        chk("rst_rem", rem, '0);
        chk("rst_ok", 64'(data_ok), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2, "u100_7");
        do_op(-64'sd100, 64'd7, 1'b1, -64'sd14, -64'sd2, "sm100_7");
        do_op(64'd100, -64'sd7, 1'b1, -64'sd14, 64'd2, "s100_m7");
        do_op(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, "divzero");
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              64'h8000_0000_0000_0000, 64'd0, "ovf");
        do_op(64'd3, 64'd10, 1'b1, 64'd0, 64'd3, "s3_10");
        do_op(-64'sd3, 64'd10, 1'b1, 64'd0, -64'sd3, "sm3_10");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0,
              64'd1, 64'h7FFF_FFFF_FFFF_FFFE, "u_big");
        do_op(64'h8000_0000_0000_0000, 64'd2, 1'b1,
              64'hC000_0000_0000_0000, 64'd0, "mneg_2");

        for (int i = 0; i < 4; i++) begin
            ra = {$urandom(), $urandom()};
            rb = (i < 2) ? {32'd0, $urandom()} : {$urandom(), $urandom()};
            rs = 1'(i & 1);
            e  = model(ra, rb, rs);
            do_op(ra, rb, rs, e[2*W-1:W], e[W-1:0], "rand");
        end

        // abort at BUSY cycle 10
        srca = 64'd500; srcb = 64'd9; is_signed = 1'b0; valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_ok", 64'(data_ok), 64'(0));
        chk("abort_quot", quot, last_q);
        chk("abort_rem", rem, last_r);
        hi = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (data_ok) hi++;
        end
        chk("abort_no_ok", 64'(hi), 64'(0));

        // back-to-back with valid held
        sb.push_back({64'd142, 64'd6});
        srca = 64'd1000; srcb = 64'd7; is_signed = 1'b0; valid = 1'b1;
        wait_done(n, nb);
        chk("b2b1_lat", 64'(n), 64'(W + 1));
        pop_cmp("b2b1");
        srca = -64'sd1000; srcb = 64'd7; is_signed = 1'b1;
        sb.push_back({-64'sd142, -64'sd6});
        @(posedge clk);
        #1;
        chk("b2b_gap_ok", 64'(data_ok), 64'(0));
        chk("b2b_gap_busy", 64'(busy), 64'(0));
        wait_done(n, nb);
        valid = 1'b0;
        chk("b2b2_lat", 64'(n), 64'(W + 1));
        pop_cmp("b2b2");
        @(posedge clk);
        #1;
        chk("b2b2_pulse", 64'(data_ok), 64'(0));

        // reset between edges mid-BUSY, valid held through release
        srca = 64'd1000; srcb = 64'd3; is_signed = 1'b0; valid = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("mrst_quot", quot, '0);
        chk("mrst_rem", rem, '0);
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_ok", 64'(data_ok), 64'(0));
        sb.push_back({64'd333, 64'd1});
        @(negedge clk);
        resetn = 1'b1;
        wait_done(n, nb);
        valid = 1'b0;
        chk("mrst_lat", 64'(n), 64'(W + 1));
        pop_cmp("mrst");
        @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_iter.md
DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; iteration count equals WIDTH.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 valid  input  1  request from the ALU; held high until data_ok is seen; dropping it withdraws the request.
REQ-005 is_signed  input  1  1 = signed div/rem, 0 = unsigned; sampled at accept.
REQ-006 srca  input  WIDTH  dividend; sampled at accept.
REQ-007 srcb  input  WIDTH  divisor; sampled at accept.
REQ-008 quot  output  WIDTH  quotient, registered.
REQ-009 rem  output  WIDTH  remainder, registered.
REQ-010 data_ok  output  1  single-cycle pulse; quot/rem are valid in this cycle.
REQ-011 busy  output  1  high in BUSY state.

Function
REQ-012 The block SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-013 IDLE with valid=1 at a rising edge SHALL accept the request: latch operands, is_signed and operand signs, load |srca| (unsigned if is_signed=0) into the working dividend, clear the partial remainder, load the iteration counter with WIDTH, and go to BUSY.
REQ-014 Each BUSY cycle SHALL perform one restoring shift-subtract step: shift {rem,dividend} left 1; if shifted rem >= |divisor|, subtract and set quotient bit to 1, else 0; decrement the counter.
REQ-015 After WIDTH BUSY cycles the FSM SHALL enter DONE; accept in cycle N gives data_ok high in cycle N+WIDTH+1 (65 cycles for WIDTH=64).
REQ-016 Entering DONE SHALL write quot/rem with sign fixup: quotient negated when is_signed and operand signs differ; remainder negated when is_signed and dividend negative.
REQ-017 DONE SHALL assert data_ok for exactly one cycle and return to IDLE unconditionally; valid is ignored in DONE, and a request still high is accepted in the following IDLE cycle, not the DONE cycle.
REQ-018 quot/rem SHALL hold their last values from DONE until the next DONE or reset.
REQ-019 valid=0 sampled in BUSY SHALL abort: go to IDLE next cycle, no data_ok, quot/rem unchanged.
REQ-020 Divisor zero at accept SHALL skip BUSY: go directly to DONE with quot = all ones and rem = srca (latency 1 cycle).
REQ-021 Signed overflow (srca = most-negative value, srcb = -1, is_signed=1) SHALL yield quot = srca and rem = 0 through the normal datapath with WIDTH-bit wrap. No special case is required.
REQ-022 Magnitude negation SHALL use WIDTH-bit two's complement; the most-negative value maps to itself and is treated as unsigned 2^(WIDTH-1).

Reset
REQ-023 resetn=0 SHALL immediately force state=IDLE, counter=0, data_ok=0, busy=0, quot=0, rem=0, independent of clk.
REQ-024 Reset asserted mid-BUSY SHALL discard the operation; after release the block SHALL accept a held valid on the first rising edge with resetn=1.

Configuration
REQ-025 Macro DIVIDER_ITER_EARLY_EXIT_EN: when defined, an accept with nonzero divisor and |dividend| < |divisor| (unsigned compare of magnitudes) SHALL go directly to DONE with quotient 0 and remainder = srca (latency 1 cycle).
REQ-026 Without DIVIDER_ITER_EARLY_EXIT_EN, every nonzero-divisor request SHALL take the full WIDTH+1 cycle latency; results are identical in both builds.

Verification
REQ-027 Unsigned: srca=100, srcb=7, is_signed=0, valid held -> data_ok in cycle 65 after accept, quot=14, rem=2, busy high for 64 cycles.
REQ-028 Signed: srca=-100, srcb=7 -> quot=-14, rem=-2. Also srca=100, srcb=-7 -> quot=-14, rem=2.
REQ-029 Divide by zero: srca=0x1234, srcb=0 -> data_ok one cycle after accept, quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234.
REQ-030 Overflow: srca=0x8000_0000_0000_0000, srcb=-1, signed -> quot=0x8000_0000_0000_0000, rem=0.
REQ-031 Abort/back-to-back: drop valid at BUSY cycle 10 -> no data_ok, IDLE next cycle. Then hold valid across two ops -> second accept occurs the cycle after the first data_ok, and data_ok is never high for two consecutive cycles.
REQ-032 Reset: assert resetn=0 mid-BUSY between clock edges -> outputs zero immediately. With DIVIDER_ITER_EARLY_EXIT_EN defined, srca=3, srcb=10 -> data_ok one cycle after accept, quot=0, rem=3.
